// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg
//   Shared definitions for the multi-cycle RV64 control path: the 4-bit
//   sequencer state encoding, the base-ISA opcodes the sequencer dispatches on
//   (also used by the immediate decoder), the branch funct3 codes, and the
//   encodings of every datapath mux select and ALU operation.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_LD   = 4'd6,
    S_MEM_ST   = 4'd7,
    S_WB_ALU   = 4'd8,
    S_WB_LOAD  = 4'd9,
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11,
    S_ILLEGAL  = 4'd12,
    S_HALT     = 4'd13
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic       ADDR_PC     = 1'b0;
  localparam logic       ADDR_ALUOUT = 1'b1;

  localparam logic       PC_SRC_ALU    = 1'b0;
  localparam logic       PC_SRC_ALUOUT = 1'b1;

  localparam logic [1:0] ALU_A_PC    = 2'd0;
  localparam logic [1:0] ALU_A_RS1   = 2'd1;
  localparam logic [1:0] ALU_A_OLDPC = 2'd2;

  localparam logic [1:0] ALU_B_RS2  = 2'd0;
  localparam logic [1:0] ALU_B_FOUR = 2'd1;
  localparam logic [1:0] ALU_B_IMM  = 2'd2;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MEM    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;

  // Next state out of DECODE. AUIPC goes straight to writeback because DECODE
  // has already computed oldPC+imm into ALUOut.
  function automatic state_t dispatch(input logic [6:0] opcode);
    state_t nxt;
    case (opcode)
      OP_R:              nxt = S_EXEC_R;
      OP_IMM:            nxt = S_EXEC_I;
      OP_LOAD, OP_STORE: nxt = S_MEM_ADDR;
      OP_BRANCH:         nxt = S_BRANCH;
      OP_JAL:            nxt = S_JAL;
      OP_AUIPC:          nxt = S_WB_ALU;
      default:           nxt = S_ILLEGAL;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// multicycle_control
//   Multi-cycle sequencer for the RV64 datapath. One FSM steps each instruction
//   through fetch, decode, execute, memory and writeback and drives the datapath
//   mux selects and enables. It also counts retired instructions.
// Parameters
//   CNT_WIDTH    width of the instret counter (wraps modulo 2^CNT_WIDTH)
//   HALT_ON_ILL  1: an illegal instruction halts until reset; 0: skip it
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   opcode        IR[6:0]
//   funct3        IR[14:12]
//   alu_zero      ALU result == 0
//   mem_ready     memory handshake done
//   mem_req       memory request (held until mem_ready)
//   mem_we        1 = store
//   mem_addr_sel  0 = PC, 1 = ALUOut
//   ir_write      latch instruction and oldPC
//   pc_write      update PC
//   pc_src        0 = ALU result, 1 = ALUOut
//   reg_write     regfile write enable
//   alu_src_a     0 = PC, 1 = rs1, 2 = oldPC
//   alu_src_b     0 = rs2, 1 = const 4, 2 = immediate
//   alu_op        00 add, 01 sub, 10 decode funct3/funct7
//   wb_sel        0 = ALUOut, 1 = mem data, 2 = PC
//   illegal       sticky illegal-instruction flag
//   instret       retired-instruction count
module multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH   = 64,
  parameter bit HALT_ON_ILL = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 alu_zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 mem_addr_sel,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_src,
  output logic                 reg_write,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic [1:0]           wb_sel,
  output logic                 illegal,
  output logic [CNT_WIDTH-1:0] instret
);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] instret_q, instret_d;
  logic                 illegal_q, illegal_d;
  logic                 retire;
  logic                 branch_f3_ok;

  assign branch_f3_ok = (funct3 == F3_BEQ) || (funct3 == F3_BNE);

  // Next-state logic. 'retire' marks the cycle an instruction completes, so
  // the counter advances exactly once per instruction.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    case (state_q)
      S_IDLE:     state_d = S_FETCH;
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE:   state_d = dispatch(opcode);
      S_EXEC_R,
      S_EXEC_I:   state_d = S_WB_ALU;
      S_MEM_ADDR: state_d = opcode[5] ? S_MEM_ST : S_MEM_LD;
      S_MEM_LD:   if (mem_ready) state_d = S_WB_LOAD;
      S_MEM_ST: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_WB_ALU,
      S_WB_LOAD,
      S_JAL: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_BRANCH: begin
        if (branch_f3_ok) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else begin
          state_d = S_ILLEGAL;
        end
      end
      S_ILLEGAL: begin
        illegal_d = 1'b1;
        state_d   = HALT_ON_ILL ? S_HALT : S_FETCH;
      end
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_IDLE;
    endcase
    instret_d = retire ? instret_q + CNT_WIDTH'(1) : instret_q;
  end

  // State, sticky illegal flag and retire counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      instret_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
    end
  end

  // Datapath controls decoded from state. The only input dependences are the
  // fetch handshake (latch IR / advance PC when the word arrives) and the
  // branch decision.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = ADDR_PC;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_SRC_ALU;
    reg_write    = 1'b0;
    alu_src_a    = ALU_A_PC;
    alu_src_b    = ALU_B_RS2;
    alu_op       = ALUOP_ADD;
    wb_sel       = WB_ALUOUT;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = ALU_B_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = ALU_A_OLDPC;
        alu_src_b = ALU_B_IMM;
      end
      S_EXEC_R: begin
        alu_src_a = ALU_A_RS1;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        alu_src_a = ALU_A_RS1;
        alu_src_b = ALU_B_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      S_MEM_ADDR: begin
        alu_src_a = ALU_A_RS1;
        alu_src_b = ALU_B_IMM;
      end
      S_MEM_LD: begin
        mem_req      = 1'b1;
        mem_addr_sel = ADDR_ALUOUT;
      end
      S_MEM_ST: begin
        mem_req      = 1'b1;
        mem_we       = 1'b1;
        mem_addr_sel = ADDR_ALUOUT;
      end
      S_WB_ALU:  reg_write = 1'b1;
      S_WB_LOAD: begin
        reg_write = 1'b1;
        wb_sel    = WB_MEM;
      end
      S_BRANCH: begin
        alu_src_a = ALU_A_RS1;
        alu_op    = ALUOP_SUB;
        pc_src    = PC_SRC_ALUOUT;
        // Unsupported funct3 must not redirect the PC.
        case (funct3)
          F3_BEQ:  pc_write = alu_zero;
          F3_BNE:  pc_write = !alu_zero;
          default: pc_write = 1'b0;
        endcase
      end
      S_JAL: begin
        reg_write = 1'b1;
        wb_sel    = WB_PC;
        pc_write  = 1'b1;
        pc_src    = PC_SRC_ALUOUT;
      end
      default: ;
    endcase
  end

  assign illegal = illegal_q;
  assign instret = instret_q;

endmodule
